// File: rtl/tcam_pkg.sv
// -----------------------------------------------------------------------------
// tcam_pkg
// Shared types and helpers for the pipelined TCAM (tcam_pipe).
//   - tcam_state_e : flush walker state (IDLE, FLUSH, DRAIN)
//   - clog2        : ceiling log2, never below 1 (usable as a bus width)
//   - *_D          : default key / address / data widths
// No ports.
// -----------------------------------------------------------------------------
package tcam_pkg;

   localparam int KEY_WIDTH_D  = 8;
   localparam int ADDR_WIDTH_D = 4;
   localparam int DATA_WIDTH_D = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } tcam_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// -----------------------------------------------------------------------------
// tcam_prio_enc
// Combinational priority encoder over an N-bit hit vector.
// Ports:
//   vec   in  N   hit vector, bit i = entry i matched
//   idx   out IW  index of the lowest set bit (0 when vec is empty)
//   any   out 1   at least one bit set
//   multi out 1   more than one bit set
// -----------------------------------------------------------------------------
module tcam_prio_enc
   import tcam_pkg::*;
#(
   parameter int N  = 16,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);

   // Walk from the top down so the lowest set bit is the last to assign.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

   assign any   = |vec;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/tcam_pipe.sv
// -----------------------------------------------------------------------------
// tcam_pipe
// Pipelined ternary CAM with per-entry valid bits, a write/invalidate port,
// a valid/ready search port and a valid/ready result port with backpressure.
// A flush walker clears one valid bit per cycle. Search pipeline:
//   S1 : match vector registered on accept
//   S2 : lowest-index encode, multi flag and data read registered
// Optional build macro: TCAM_STATS_EN adds saturating hit_cnt / miss_cnt.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, inv_en, wr_addr   write / invalidate entry (inv_en wins)
//   wr_key, wr_mask, wr_data entry contents (mask bit 1 = don't care)
//   flush, busy              start flush walker / walker active
//   s_valid, s_ready, s_key  search request handshake and key
//   r_valid, r_ready         result handshake
//   r_hit, r_multi           any / more than one valid entry matched
//   r_addr, r_data           lowest matching index and its data (0 on miss)
//   hit_cnt, miss_cnt        consumed-result counters (TCAM_STATS_EN only)
// -----------------------------------------------------------------------------
module tcam_pipe
   import tcam_pkg::*;
#(
   parameter int KEY_WIDTH  = KEY_WIDTH_D,
   parameter int ADDR_WIDTH = ADDR_WIDTH_D,
   parameter int DATA_WIDTH = DATA_WIDTH_D
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  inv_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [KEY_WIDTH-1:0]  wr_key,
   input  logic [KEY_WIDTH-1:0]  wr_mask,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flush,
   output logic                  busy,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [KEY_WIDTH-1:0]  s_key,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic                  r_hit,
   output logic                  r_multi,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
`ifdef TCAM_STATS_EN
   ,
   output logic [15:0]           hit_cnt,
   output logic [15:0]           miss_cnt
`endif
);

   localparam int ENTRIES = 2 ** ADDR_WIDTH;
   localparam int STAGES  = 2;

   // ---------------------------------------------------------------- storage
   logic [ENTRIES-1:0]                 valid_q;
   logic [ENTRIES-1:0][KEY_WIDTH-1:0]  key_q;
   logic [ENTRIES-1:0][KEY_WIDTH-1:0]  mask_q;
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] data_q;

   // ---------------------------------------------------------------- control
   tcam_state_e           state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic                  flush_start;
   logic                  flush_clr;

   // --------------------------------------------------------------- pipeline
   logic [STAGES:1]       vld_pipe;   // [1] = S1 holds a search, [2] = result
   logic [ENTRIES-1:0]    match;
   logic [ENTRIES-1:0]    s1_match;
   logic                  adv;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] enc_idx;
   logic                  enc_any;
   logic                  enc_multi;

   assign busy    = (state != IDLE);
   assign adv     = ~vld_pipe[STAGES] | r_ready;
   assign s_ready = adv & (state == IDLE) & ~rst;
   assign accept  = s_valid & s_ready;
   assign r_valid = vld_pipe[STAGES];

   // ------------------------------------------------------------ match array
   for (genvar i = 0; i < ENTRIES; i++) begin : g_match
      assign match[i] = valid_q[i] & ~|((s_key ^ key_q[i]) & ~mask_q[i]);
   end

   // ------------------------------------------------------------ flush walker
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      flush_start = 1'b0;
      flush_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               state_nxt   = FLUSH;
               cnt_nxt     = '0;
               flush_start = 1'b1;
            end
         end
         FLUSH: begin
            flush_clr = 1'b1;
            cnt_nxt   = cnt + 1'b1;   // wraps back to 0 after the last entry
            if (&cnt) state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // --------------------------------------------------------- entry storage
   // Writes and invalidates are dropped while the walker owns the valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         key_q   <= '0;
         mask_q  <= '0;
         data_q  <= '0;
      end else if (flush_clr) begin
         valid_q[cnt] <= 1'b0;
      end else if (!busy) begin
         if (inv_en) begin
            valid_q[wr_addr] <= 1'b0;
         end else if (wr_en) begin
            valid_q[wr_addr] <= 1'b1;
            key_q[wr_addr]   <= wr_key;
            mask_q[wr_addr]  <= wr_mask;
            data_q[wr_addr]  <= wr_data;
         end
      end
   end

   // ------------------------------------------------------------- S2 encode
   tcam_prio_enc #(
      .N  (ENTRIES),
      .IW (ADDR_WIDTH)
   ) u_enc (
      .vec   (s1_match),
      .idx   (enc_idx),
      .any   (enc_any),
      .multi (enc_multi)
   );

   // ---------------------------------------------------------- S1/S2 stages
   // Both stages move together on adv, so a stalled result freezes S1 too
   // and the outputs stay stable until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_match <= '0;
         r_hit    <= 1'b0;
         r_multi  <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};
         if (accept) s1_match <= match;
         if (vld_pipe[1]) begin
            r_hit   <= enc_any;
            r_multi <= enc_multi;
            r_addr  <= enc_any ? enc_idx : '0;
            // data array is read now, so a write landing between S1 and S2
            // is visible in r_data
            r_data  <= enc_any ? data_q[enc_idx] : '0;
         end
      end
   end

`ifdef TCAM_STATS_EN
   // ------------------------------------------------------------ statistics
   always_ff @(posedge clk) begin
      if (rst || flush_start) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (r_valid && r_ready) begin
         if (r_hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
         end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tcam_pipe.sv
// -----------------------------------------------------------------------------
// tb_tcam_pipe
// Directed self-checking bench for tcam_pipe (default 8/4/8 configuration).
// -----------------------------------------------------------------------------
module tb_tcam_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, inv_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_key, wr_mask, wr_data;
   logic       flush, busy;
   logic       s_valid, s_ready;
   logic [7:0] s_key;
   logic       r_valid, r_ready;
   logic       r_hit, r_multi;
   logic [3:0] r_addr;
   logic [7:0] r_data;
`ifdef TCAM_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tcam_pipe dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .inv_en  (inv_en),
      .wr_addr (wr_addr),
      .wr_key  (wr_key),
      .wr_mask (wr_mask),
      .wr_data (wr_data),
      .flush   (flush),
      .busy    (busy),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_key   (s_key),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .r_hit   (r_hit),
      .r_multi (r_multi),
      .r_addr  (r_addr),
      .r_data  (r_data)
`ifdef TCAM_STATS_EN
      ,
      .hit_cnt (hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic hit, input logic multi,
                          input logic [3:0] addr, input logic [7:0] data);
      chk({tag, ".r_valid"}, {31'd0, r_valid}, 32'd1);
      chk({tag, ".r_hit"},   {31'd0, r_hit},   {31'd0, hit});
      chk({tag, ".r_multi"}, {31'd0, r_multi}, {31'd0, multi});
      chk({tag, ".r_addr"},  {28'd0, r_addr},  {28'd0, addr});
      chk({tag, ".r_data"},  {24'd0, r_data},  {24'd0, data});
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] k, input logic [7:0] m,
                     input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_key = k; wr_mask = m; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   // single search: accept, one cycle in S1, then result is on the port
   task automatic search_one(input string tag, input logic [7:0] k, input logic hit,
                             input logic multi, input logic [3:0] addr,
                             input logic [7:0] data);
      s_valid = 1'b1; s_key = k;
      step();
      s_valid = 1'b0;
      chk({tag, ".s1_rv"}, {31'd0, r_valid}, 32'd0);
      step();
      chk_res(tag, hit, multi, addr, data);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbusy;
      rst = 1'b1; wr_en = 1'b0; inv_en = 1'b0; wr_addr = '0; wr_key = '0;
      wr_mask = '0; wr_data = '0; flush = 1'b0; s_valid = 1'b0; s_key = '0;
      r_ready = 1'b1;
      step(); step();

      // reset state
      chk("rst.s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst.busy",    {31'd0, busy},    32'd0);
      chk("rst.r_valid", {31'd0, r_valid}, 32'd0);
      chk("rst.r_hit",   {31'd0, r_hit},   32'd0);
      chk("rst.r_multi", {31'd0, r_multi}, 32'd0);
      chk("rst.r_addr",  {28'd0, r_addr},  32'd0);
      chk("rst.r_data",  {24'd0, r_data},  32'd0);
      rst = 1'b0;
      step();
      chk("post_rst.s_ready", {31'd0, s_ready}, 32'd1);

      // single exact hit
      wr(4'd0, 8'hA5, 8'h00, 8'h11);
      search_one("e0_hit", 8'hA5, 1'b1, 1'b0, 4'd0, 8'h11);
      chk("e0_hit.drain", {31'd0, r_valid}, 32'd0);

      // multi hit, then invalidate the lowest
      wr(4'd3, 8'hA0, 8'h0F, 8'h33);
      wr(4'd7, 8'hA5, 8'h00, 8'h77);
      search_one("multi", 8'hA5, 1'b1, 1'b1, 4'd0, 8'h11);
      inv_en = 1'b1; wr_addr = 4'd0;
      step();
      inv_en = 1'b0;
      search_one("inv_e0", 8'hA5, 1'b1, 1'b1, 4'd3, 8'h33);

      // miss
      search_one("miss", 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00);

      // back-to-back with backpressure
      wr(4'd9, 8'h5A, 8'h00, 8'h99);
      s_valid = 1'b1; s_key = 8'hA5;
      step();
      s_key = 8'h5A;
      step();
      r_ready = 1'b0; s_key = 8'hFF;
      #1;
      chk("bp.s_ready_low", {31'd0, s_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_res("bp.hold", 1'b1, 1'b1, 4'd3, 8'h33);
         chk("bp.s_ready_hold", {31'd0, s_ready}, 32'd0);
      end
      r_ready = 1'b1;
      #1;
      chk("bp.s_ready_up", {31'd0, s_ready}, 32'd1);
      step();
      chk_res("bp.r1", 1'b1, 1'b0, 4'd9, 8'h99);
      s_key = 8'hAF;
      step();
      s_valid = 1'b0;
      chk_res("bp.r2", 1'b0, 1'b0, 4'd0, 8'h00);
      step();
      chk_res("bp.r3", 1'b1, 1'b0, 4'd3, 8'h33);
      step();
      chk("bp.drained", {31'd0, r_valid}, 32'd0);

      // flush walker: busy for ENTRIES+1 cycles, writes ignored meanwhile
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush.s_ready", {31'd0, s_ready}, 32'd0);
      nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         nbusy++;
         wr_en = (i == 2); wr_addr = 4'd0; wr_key = 8'h12; wr_mask = 8'h00;
         wr_data = 8'hEE;
         step();
      end
      wr_en = 1'b0;
      chk("flush.busy_cycles", nbusy, 32'd17);
      chk("flush.busy_done", {31'd0, busy}, 32'd0);
      search_one("flush.e9_gone", 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00);
      search_one("flush.wr_ignored", 8'h12, 1'b0, 1'b0, 4'd0, 8'h00);

      // wr_en + inv_en on the same address: invalidate wins
      wr_en = 1'b1; inv_en = 1'b1; wr_addr = 4'd2; wr_key = 8'h3C;
      wr_mask = 8'h00; wr_data = 8'hCC;
      s_valid = 1'b1; s_key = 8'h3C;
      step();
      wr_en = 1'b0; inv_en = 1'b0; s_valid = 1'b0;
      step();
      chk_res("wrinv.same_cycle", 1'b0, 1'b0, 4'd0, 8'h00);
      step();
      search_one("wrinv.after", 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);

      // search accepted with a write sees pre-write contents
      wr_en = 1'b1; wr_addr = 4'd4; wr_key = 8'h3C; wr_mask = 8'h00; wr_data = 8'h44;
      s_valid = 1'b1; s_key = 8'h3C;
      step();
      wr_en = 1'b0; s_valid = 1'b0;
      step();
      chk_res("wr_order.pre", 1'b0, 1'b0, 4'd0, 8'h00);
      step();
      search_one("wr_order.post", 8'h3C, 1'b1, 1'b0, 4'd4, 8'h44);

      // reset mid-search discards the in-flight request and the table
      s_valid = 1'b1; s_key = 8'h3C;
      step();
      s_valid = 1'b0; rst = 1'b1;
      step();
      chk("rst_mid.r_valid", {31'd0, r_valid}, 32'd0);
      rst = 1'b0;
      step();
      chk("rst_mid.r_valid2", {31'd0, r_valid}, 32'd0);
      search_one("rst_mid.cleared", 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tcam_pipe.md
Name: tcam_pipe

Overview:
Parametrised, pipelined successor to the single-port TCAM. Key/mask entries carry per-entry valid bits. A dedicated write port, a valid/ready search request port, and a valid/ready result port with backpressure share one pipeline. Adds entry invalidation, a sequential flush walker, a multi-hit flag and a registered 2-stage search pipeline. Sits between packet-header extraction and action lookup.

Parameters:
KEY_WIDTH, 8, search key / stored key / mask width
ADDR_WIDTH, 4, entry index width; ENTRIES = 2**ADDR_WIDTH
DATA_WIDTH, 8, associated data width per entry

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write entry wr_addr (key, mask, data, valid=1)
inv_en  in  1  clear valid bit of entry wr_addr
wr_addr  in  ADDR_WIDTH  target entry for write/invalidate
wr_key  in  KEY_WIDTH  stored key
wr_mask  in  KEY_WIDTH  1 = don't-care bit
wr_data  in  DATA_WIDTH  associated data
flush  in  1  pulse: start flush walker
busy  out  1  flush in progress
s_valid  in  1  search request valid
s_ready  out  1  search request accepted when s_valid&s_ready
s_key  in  KEY_WIDTH  search key
r_valid  out  1  result valid
r_ready  in  1  result consumed when r_valid&r_ready
r_hit  out  1  at least one valid entry matched
r_multi  out  1  more than one valid entry matched
r_addr  out  ADDR_WIDTH  lowest matching index (0 on miss)
r_data  out  DATA_WIDTH  data of r_addr (0 on miss)

Behaviour:
- Reset: all valid bits 0, keys/masks/data 0, FSM IDLE, busy=0, s_ready=0 during rst then 1, r_valid=0, r_hit=r_multi=0, r_addr=0, r_data=0. Reset mid-flush or mid-search discards everything.
- Match: entry i hits iff valid[i] & (((s_key ^ key[i]) & ~mask[i]) == 0).
- Pipeline: adv = ~r_valid | r_ready. S1 registers match vector on accept. S2 registers lowest-index encode, multi flag and data read. Result latency is 2 cycles accept-to-r_valid. Throughput is 1/cycle when r_ready stays high.
- s_ready = adv & (state==IDLE). When r_valid&~r_ready, S1/S2 hold and outputs stay stable.
- Write precedence: wr_en and inv_en in the same cycle -> inv_en wins.
- Writes take effect at the clock edge. A search accepted in the same cycle matches pre-write contents. r_data is read from the data array in the S2 cycle.
- FSM: IDLE -> FLUSH on flush (ignored when already FLUSH). FLUSH clears valid[cnt], cnt increments from 0. FLUSH -> DRAIN after cnt wraps from ENTRIES-1 to 0, i.e. after ENTRIES cycles. DRAIN lasts one cycle -> IDLE.
- busy=1 in FLUSH and DRAIN. wr_en/inv_en are ignored while busy. Searches already in the pipeline complete using the match vector already captured.

Optional Feature:
TCAM_STATS_EN
- Defined: adds outputs hit_cnt and miss_cnt, each 16-bit and saturating at 0xFFFF. They increment when a result is consumed (r_valid&r_ready), by r_hit. Both cleared on rst and on flush start.
- Undefined: ports and counters are absent.

Decomposition:
- Package tcam_pkg holds:
  - FSM state enum (IDLE, FLUSH, DRAIN)
  - function clog2
  - localparam defaults for key/addr/data widths
- Sub-module tcam_prio_enc (parametric N) is combinational. It outputs idx of the lowest set bit, plus any and multi. It is used in S2.

Test Plan:
- Write e0 key=0xA5 mask=0x00 data=0x11; search 0xA5 -> 2 cycles later r_hit=1, r_addr=0, r_data=0x11, r_multi=0.
- Write e3 key=0xA0 mask=0x0F data=0x33 and e7 key=0xA5 mask=0x00 data=0x77; search 0xA5 -> r_addr=0, r_multi=1. Invalidate e0, search 0xA5 -> r_addr=3, r_data=0x33, r_multi=1.
- Search 0x5A with no match -> r_hit=0, r_addr=0, r_data=0.
- Back-to-back 4 searches with r_ready=0 from cycle 3 -> s_ready drops, r_valid holds first result stable. Raising r_ready drains all 4 in order.
- flush with 16 entries -> busy=1 for 17 cycles, wr_en during busy ignored. Search after -> miss.
- wr_en and inv_en both high on the same address -> entry invalid. Same-cycle search on a new key -> miss.
